// File: rtl/seg7_pkg.sv
// Shared 7-segment constants (active-high {g,f,e,d,c,b,a}) and digit-select encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    DIG_UNITS = 1'b0,
    DIG_TENS  = 1'b1
  } dig_sel_e;

  // Active-high one-hot digit enable; bit 0 = units, bit 1 = tens.
  function automatic logic [1:0] digit_en(input dig_sel_e sel);
    return (sel == DIG_TENS) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-high segment pattern; codes 10..15 are blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_seg7_scan.sv
// Samples a 4-bit up/down count, flags direction/changes/jumps, and scans it as
// two decimal digits onto a multiplexed common-anode display; all outputs registered.
module count_seg7_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit LZ_BLANK       = 1'b1
) (
  input  logic       Clk,
  input  logic       RST,
  input  logic [3:0] CNT_IN,
  output logic [6:0] SEG,
  output logic [1:0] AN,
  output logic       DIR_UP,
  output logic       CHG,
  output logic       JUMP
);

  localparam int              DIV_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [6:0]      SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0]      AN_OFF   = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;

  logic [3:0]       cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             chg_q, chg_d;
  logic             jump_q, jump_d;
  logic             tens_q, tens_d;
  logic [3:0]       units_q, units_d;
  logic [DIV_W-1:0] div_q, div_d;
  dig_sel_e         sel_q, sel_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;

  logic [3:0]       cnt_inc, cnt_dec;
  logic [3:0]       dig_bcd;
  logic [6:0]       dig_seg;
  logic [6:0]       seg_act;

  // Sampler: cnt_q is the reference, so 4-bit wrap makes 15->0 an up step.
  always_comb begin
    cnt_inc = cnt_q + 4'd1;
    cnt_dec = cnt_q - 4'd1;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    chg_d   = 1'b0;
    jump_d  = 1'b0;
    if (CNT_IN != cnt_q) begin
      cnt_d = CNT_IN;
      chg_d = 1'b1;
      if (CNT_IN == cnt_inc) begin
        dir_d = 1'b1;
      end else if (CNT_IN == cnt_dec) begin
        dir_d = 1'b0;
      end else begin
        jump_d = 1'b1;
      end
    end
    tens_d  = (cnt_d >= 4'd10);
    units_d = tens_d ? (cnt_d - 4'd10) : cnt_d;
  end

  always_comb begin
    div_d = div_q + DIV_W'(1);
    sel_d = sel_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      sel_d = (sel_q == DIG_UNITS) ? DIG_TENS : DIG_UNITS;
    end
  end

  assign dig_bcd = (sel_q == DIG_TENS) ? {3'b000, tens_q} : units_q;

  seg7_decode u_decode (
    .bcd_i (dig_bcd),
    .seg_o (dig_seg)
  );

  // A blanked tens slot still enables AN[1] so both digits get equal on-time.
  always_comb begin
    seg_act = dig_seg;
    if (LZ_BLANK && (sel_q == DIG_TENS) && !tens_q) begin
      seg_act = SEG_BLANK;
    end
    seg_d = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
    an_d  = SEG_ACTIVE_LOW ? ~digit_en(sel_q) : digit_en(sel_q);
  end

  always_ff @(posedge Clk) begin
    if (RST) begin
      cnt_q   <= 4'd0;
      dir_q   <= 1'b1;
      chg_q   <= 1'b0;
      jump_q  <= 1'b0;
      tens_q  <= 1'b0;
      units_q <= 4'd0;
      div_q   <= '0;
      sel_q   <= DIG_UNITS;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
    end else begin
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      chg_q   <= chg_d;
      jump_q  <= jump_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      div_q   <= div_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign SEG    = seg_q;
  assign AN     = an_q;
  assign DIR_UP = dir_q;
  assign CHG    = chg_q;
  assign JUMP   = jump_q;

endmodule

// File: tb/tb_count_seg7_scan.sv
// Directed bench for count_seg7_scan; a second instance runs with leading-zero blanking off.
module tb_count_seg7_scan;

  logic       Clk = 1'b0;
  logic       RST;
  logic [3:0] CNT_IN;
  logic [6:0] SEG, seg_nb;
  logic [1:0] AN, an_nb;
  logic       DIR_UP, CHG, JUMP;
  logic       dir_nb, chg_nb, jump_nb;

  int n_cmp = 0;
  int n_bad = 0;
  int k     = 0;

  count_seg7_scan #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)) dut (
    .Clk(Clk), .RST(RST), .CNT_IN(CNT_IN), .SEG(SEG), .AN(AN),
    .DIR_UP(DIR_UP), .CHG(CHG), .JUMP(JUMP)
  );

  count_seg7_scan #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b0)) dut_nb (
    .Clk(Clk), .RST(RST), .CNT_IN(CNT_IN), .SEG(seg_nb), .AN(an_nb),
    .DIR_UP(dir_nb), .CHG(chg_nb), .JUMP(jump_nb)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    k++;
  endtask

  // Slot shown after edge kk (kk=1 is the first edge after reset release): 0 units, 1 tens.
  function automatic int slot(input int kk);
    return ((kk - 1) / 4) % 2;
  endfunction

  task automatic scan_check(input string tag, input logic [6:0] u_seg,
                            input logic [6:0] t_seg, input logic [6:0] t_seg_nb);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (slot(k) == 0) begin
        chk({tag, " units AN"}, AN, 2'b10);
        chk({tag, " units SEG"}, SEG, u_seg);
        chk({tag, " units SEG nb"}, seg_nb, u_seg);
      end else begin
        chk({tag, " tens AN"}, AN, 2'b01);
        chk({tag, " tens SEG"}, SEG, t_seg);
        chk({tag, " tens SEG nb"}, seg_nb, t_seg_nb);
      end
    end
  endtask

  logic [3:0] dn [4] = '{4'd2, 4'd1, 4'd0, 4'd15};

  initial begin
    // Reset
    RST = 1'b1;
    CNT_IN = 4'd0;
    repeat (3) tick();
    chk("rst SEG", SEG, 7'h7F);
    chk("rst AN", AN, 2'b11);
    chk("rst DIR_UP", DIR_UP, 1'b1);
    chk("rst CHG", CHG, 1'b0);
    chk("rst JUMP", JUMP, 1'b0);
    RST = 1'b0;
    k = 0;
    tick();
    chk("post-rst AN", AN, 2'b10);
    chk("post-rst SEG", SEG, 7'h40);

    // Count up 1..15, 0
    for (int v = 1; v <= 16; v++) begin
      CNT_IN = 4'(v);
      tick();
      chk("up CHG", CHG, 1'b1);
      chk("up DIR_UP", DIR_UP, 1'b1);
      chk("up JUMP", JUMP, 1'b0);
      tick();
      chk("up CHG pulse end", CHG, 1'b0);
      repeat (6) tick();
    end

    // Count down 3,2,1,0,15 (0->3 is a jump)
    CNT_IN = 4'd3;
    tick();
    chk("0->3 JUMP", JUMP, 1'b1);
    chk("0->3 DIR_UP held", DIR_UP, 1'b1);
    repeat (7) tick();
    for (int i = 0; i < 4; i++) begin
      CNT_IN = dn[i];
      tick();
      chk("dn DIR_UP", DIR_UP, 1'b0);
      chk("dn JUMP", JUMP, 1'b0);
      chk("dn CHG", CHG, 1'b1);
      repeat (7) tick();
      chk("dn DIR_UP stays", DIR_UP, 1'b0);
    end

    // Display 13 (15->13 is a jump, direction held down)
    CNT_IN = 4'd13;
    tick();
    chk("15->13 JUMP", JUMP, 1'b1);
    chk("15->13 DIR_UP held", DIR_UP, 1'b0);
    tick();
    scan_check("cnt13", 7'h30, 7'h79, 7'h79);

    // Leading-zero blank with 5
    CNT_IN = 4'd5;
    tick();
    tick();
    scan_check("cnt5", 7'h12, 7'h7F, 7'h40);

    // Jump 4->9
    CNT_IN = 4'd4;
    tick();
    chk("5->4 DIR_UP", DIR_UP, 1'b0);
    tick();
    CNT_IN = 4'd9;
    tick();
    chk("4->9 JUMP", JUMP, 1'b1);
    chk("4->9 CHG", CHG, 1'b1);
    chk("4->9 DIR_UP held", DIR_UP, 1'b0);
    tick();
    chk("4->9 JUMP end", JUMP, 1'b0);
    chk("4->9 CHG end", CHG, 1'b0);
    chk("4->9 DIR_UP after", DIR_UP, 1'b0);

    // Reset in the middle of a tens slot
    begin
      int guard = 0;
      while (!(slot(k) == 1 && ((k - 1) % 4) == 1) && guard < 20) begin
        tick();
        guard++;
      end
      chk("mid tens AN", AN, 2'b01);
    end
    RST = 1'b1;
    CNT_IN = 4'd0;
    tick();
    chk("mid-rst SEG", SEG, 7'h7F);
    chk("mid-rst AN", AN, 2'b11);
    chk("mid-rst DIR_UP", DIR_UP, 1'b1);
    chk("mid-rst CHG", CHG, 1'b0);
    RST = 1'b0;
    k = 0;
    tick();
    chk("re-run units AN", AN, 2'b10);
    chk("re-run units SEG", SEG, 7'h40);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("re-run units hold AN", AN, 2'b10);
    end
    tick();
    chk("re-run tens AN", AN, 2'b01);
    chk("re-run tens SEG blank", SEG, 7'h7F);
    chk("re-run tens SEG nb", seg_nb, 7'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
